debounce_multi: RTL
===================

// Module: debounce_multi
// PURPOSE
//   Parametrised N-channel push-button/switch debouncer. Per channel:
//   synchroniser, stability counter, accepted-state register, one-cycle edge strobes.
//   Sits between raw board inputs and the user logic, one instance per input bank.
//   Adds asynchronous reset, input synchronisation, per-channel reset levels,
//   and rise/fall event outputs.
// PARAMETERS
//   CHANNELS    4       number of independent input channels (>=1)
//   MAX_COUNT   250000  consecutive disagreeing samples required to accept a new level (>=1)
//   CNT_W       18      counter width; must satisfy 2**CNT_W > MAX_COUNT
//   SYNC_STAGES 2       synchroniser flops per channel (>=2)
//   INIT        0       CHANNELS-bit vector; per-channel level used at reset
// PORTS
//   CLK     in   1         system clock, all logic on posedge
//   RST     in   1         asynchronous, active-high reset
//   i_BUT   in   CHANNELS  raw asynchronous inputs
//   o_BUT   out  CHANNELS  debounced levels
//   o_RISE  out  CHANNELS  1-cycle strobe: o_BUT[n] just went 0->1
//   o_FALL  out  CHANNELS  1-cycle strobe: o_BUT[n] just went 1->0
//   o_EVENT out  1         OR of all o_RISE|o_FALL bits, same cycle
// BEHAVIOUR
// - Reset (RST=1, async assert; release registered on CLK):
//   sync chain[n] = INIT[n], o_BUT = INIT, count[n] = 0,
//   o_RISE = o_FALL = 0, o_EVENT = 0.
//   Asserting reset mid-count discards the count; no strobe fires.
// - Synchroniser: i_BUT[n] passes through SYNC_STAGES flops. s[n] is the last stage.
// - Per channel, on each CLK edge:
//   * s[n] == o_BUT[n]: count[n] <= 0 (any glitch restarts the qualification).
//   * s[n] != o_BUT[n] and count[n] <  MAX_COUNT-1: count[n] <= count[n]+1.
//   * s[n] != o_BUT[n] and count[n] == MAX_COUNT-1:
//     o_BUT[n] <= s[n]; count[n] <= 0; o_RISE[n] <= s[n]; o_FALL[n] <= ~s[n].
//   * o_RISE/o_FALL are 0 in every other cycle. Both are registered and
//     coincide with the first cycle of the new o_BUT level.
// - Per-channel states: STABLE (count=0, s==o_BUT) and QUALIFYING (count>0).
//   QUALIFYING -> STABLE either by acceptance or by s reverting.
// - Latency: a clean step on i_BUT[n] first appears on s[n] after SYNC_STAGES edges.
//   o_BUT[n] changes MAX_COUNT edges after that: SYNC_STAGES+MAX_COUNT edges in total.
//   MAX_COUNT=1 gives acceptance on the first disagreeing sample.
// - The counter never exceeds MAX_COUNT-1; there is no wrap-around.
// - Channels are fully independent. Simultaneous acceptances on several channels
//   each raise their own strobe in the same cycle; o_EVENT = |(o_RISE|o_FALL).
// - A pulse shorter than MAX_COUNT samples is ignored entirely.
// - An input held at the new level forever produces exactly one strobe.
// TESTING  (bench: CHANNELS=4, MAX_COUNT=4, SYNC_STAGES=2, INIT=4'b0010)
// - Reset: RST=1 with i_BUT toggling -> o_BUT=4'b0010, o_RISE=o_FALL=0.
//   Release, i_BUT=4'b0010 held 20 cycles -> no strobes.
// - Clean press ch0: i_BUT[0] 0->1 at edge k -> o_BUT[0]=1 and o_RISE[0]=1
//   exactly at edge k+6; o_RISE[0]=0 at k+7; o_EVENT mirrors it.
// - Bounce ch0: pattern 1,0,1,1,0 (one per cycle), then steady 1 -> no change
//   during bounce; acceptance 6 edges after the last 0->1 step.
//   Exactly one o_RISE[0] pulse.
// - Glitch reject: ch1 (at 1) drops to 0 for 3 cycles -> o_BUT[1] stays 1,
//   o_FALL[1] never asserts.
// - Simultaneous: ch2 and ch3 driven 0->1 on the same edge -> o_RISE=4'b1100 in a
//   single cycle, o_EVENT=1 for one cycle.
// - Reset mid-op: ch0 qualifying with count=3, RST pulsed asynchronously between
//   edges -> o_BUT[0] returns to 0 immediately, no strobe. After release a held
//   1 needs the full 6 edges again.

Source files
------------

// File: rtl/debounce_multi_if.sv
// Debouncer bus: raw inputs in, debounced levels and edge strobes out.
interface debounce_multi_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] i_BUT;
  logic [CHANNELS-1:0] o_BUT;
  logic [CHANNELS-1:0] o_RISE;
  logic [CHANNELS-1:0] o_FALL;
  logic                o_EVENT;

  modport master (
    output i_BUT,
    input  o_BUT,
    input  o_RISE,
    input  o_FALL,
    input  o_EVENT
  );

  modport slave (
    input  i_BUT,
    output o_BUT,
    output o_RISE,
    output o_FALL,
    output o_EVENT
  );
endinterface

// File: rtl/debounce_multi.sv
// N-channel debouncer: synchroniser, stability counter,
// accepted level and registered rise/fall strobes per channel.
module debounce_multi #(
  parameter int                   CHANNELS    = 4,
  parameter int                   MAX_COUNT   = 250000,
  parameter int                   CNT_W       = 18,
  parameter int                   SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0]  INIT        = '0
) (
  input  logic             CLK,
  input  logic             RST,
  debounce_multi_if.slave  bus
);

  typedef enum logic {
    STABLE,
    QUALIFYING
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_COUNT - 1);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  state_e [CHANNELS-1:0]                state_q, state_d;
  logic [CHANNELS-1:0]                  but_q, but_d;
  logic [CHANNELS-1:0]                  rise_q, rise_d;
  logic [CHANNELS-1:0]                  fall_q, fall_d;
  logic [CHANNELS-1:0]                  s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = bus.i_BUT;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    but_d   = but_q;
    rise_d  = '0;
    fall_d  = '0;
    cnt_d   = '0;
    state_d = state_q;
    for (int n = 0; n < CHANNELS; n++) begin
      unique case (state_q[n])
        STABLE: begin
          if (s[n] != but_q[n]) begin
            if (cnt_q[n] == LAST) begin
              but_d[n]  = s[n];
              rise_d[n] = s[n];
              fall_d[n] = ~s[n];
            end else begin
              cnt_d[n]   = cnt_q[n] + CNT_W'(1);
              state_d[n] = QUALIFYING;
            end
          end
        end
        QUALIFYING: begin
          // Any sample that agrees again abandons the run.
          if (s[n] == but_q[n]) begin
            state_d[n] = STABLE;
          end else if (cnt_q[n] == LAST) begin
            but_d[n]   = s[n];
            rise_d[n]  = s[n];
            fall_d[n]  = ~s[n];
            state_d[n] = STABLE;
          end else begin
            cnt_d[n] = cnt_q[n] + CNT_W'(1);
          end
        end
        default: state_d[n] = STABLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= {SYNC_STAGES{INIT}};
      cnt_q  <= '0;
      but_q  <= INIT;
      rise_q <= '0;
      fall_q <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        state_q[n] <= STABLE;
      end
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      but_q   <= but_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      state_q <= state_d;
    end
  end

  assign bus.o_BUT   = but_q;
  assign bus.o_RISE  = rise_q;
  assign bus.o_FALL  = fall_q;
  assign bus.o_EVENT = |(rise_q | fall_q);

endmodule
